// File: rtl/line_ram_scheduler_pkg.sv
// rtl/line_ram_scheduler_pkg.sv - shared state encoding and reset constants for the line-RAM scheduler
package line_ram_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_IN_LINE   = 2'd2
    } state_t;

    localparam logic [3:0] WR_SEL_RESET    = 4'b1000;
    localparam logic [1:0] RD_CENTER_RESET = 2'd1;

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/line_ram_scheduler.sv
// rtl/line_ram_scheduler.sv - rotates four line RAMs per CSI line and generates write address / output qualifier
module line_ram_scheduler
    import line_ram_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 12,
    parameter int MIN_LINES  = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  frame_start_i,
    input  logic                  frame_end_i,
    input  logic                  line_valid_i,
    input  logic                  data_valid_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [3:0]            wr_sel_o,
    output logic [1:0]            rd_center_o,
    output logic                  line_odd_o,
    output logic [CNT_WIDTH-1:0]  line_count_o,
    output logic                  out_enable_o,
    output logic                  overflow_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MIN   = CNT_WIDTH'(MIN_LINES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_lv_d;
    logic                    w_line_start;
    logic                    w_rotate;
    logic [3:0]              r_wr_sel;
    logic [1:0]              r_rd_center;
    logic [CNT_WIDTH-1:0]    r_line_count;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic                    r_out_enable;
    logic                    r_overflow;
    logic [3:0]              w_sel_base;
    logic [1:0]              w_rd_base;
    logic [CNT_WIDTH-1:0]    w_cnt_base;

    assign w_line_start = line_valid_i & ~r_lv_d;

    // Frame end wins over everything; a frame start may coincide with the first line start.
    always_comb begin
        w_state_nxt = r_state;
        w_rotate    = 1'b0;
        if (frame_end_i) begin
            w_state_nxt = ST_IDLE;
        end else if (frame_start_i) begin
            w_state_nxt = w_line_start ? ST_IN_LINE : ST_WAIT_LINE;
            w_rotate    = w_line_start;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_WAIT_LINE: begin
                    if (w_line_start) begin
                        w_state_nxt = ST_IN_LINE;
                        w_rotate    = 1'b1;
                    end
                end
                ST_IN_LINE: begin
                    if (!line_valid_i) begin
                        w_state_nxt = ST_WAIT_LINE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_lv_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lv_d  <= line_valid_i;
        end
    end

    always_comb begin
        w_sel_base = r_wr_sel;
        w_rd_base  = r_rd_center;
        w_cnt_base = r_line_count;
        if (frame_start_i) begin
            w_sel_base = WR_SEL_RESET;
            w_rd_base  = RD_CENTER_RESET;
            w_cnt_base = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_sel     <= WR_SEL_RESET;
            r_rd_center  <= RD_CENTER_RESET;
            r_line_count <= '0;
        end else if (w_rotate) begin
            r_wr_sel     <= rotl4(w_sel_base);
            r_rd_center  <= w_rd_base + 2'd1;
            r_line_count <= (w_cnt_base == CNT_MAX) ? w_cnt_base : w_cnt_base + CNT_ONE;
        end else begin
            r_wr_sel     <= w_sel_base;
            r_rd_center  <= w_rd_base;
            r_line_count <= w_cnt_base;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_addr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (!line_valid_i) begin
                r_wr_addr <= '0;
            end else if (data_valid_i && (r_wr_addr != ADDR_MAX)) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (frame_start_i) begin
                r_overflow <= 1'b0;
            end else if (line_valid_i && data_valid_i && (r_wr_addr == ADDR_MAX)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_out_enable <= 1'b0;
        end else begin
            r_out_enable <= (r_state == ST_IN_LINE) && data_valid_i && (r_line_count >= CNT_MIN);
        end
    end

    assign wr_addr_o    = r_wr_addr;
    assign wr_sel_o     = r_wr_sel;
    assign rd_center_o  = r_rd_center;
    assign line_count_o = r_line_count;
    assign line_odd_o   = r_line_count[0];
    assign out_enable_o = r_out_enable;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_line_ram_scheduler.sv
// tb/tb_line_ram_scheduler.sv - directed self-checking bench for line_ram_scheduler
module tb_line_ram_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        line_valid = 1'b0;
    logic        data_valid = 1'b0;

    logic [9:0]  d_addr;
    logic [3:0]  d_sel;
    logic [1:0]  d_rd;
    logic        d_odd;
    logic [11:0] d_cnt;
    logic        d_oe;
    logic        d_ov;

    logic [2:0]  a_addr;
    logic [3:0]  a_sel;
    logic [1:0]  a_rd;
    logic        a_odd;
    logic [1:0]  a_cnt;
    logic        a_oe;
    logic        a_ov;

    int total = 0;
    int bad = 0;

    logic [3:0]  snap_sel;
    logic [1:0]  snap_rd;
    logic [11:0] snap_cnt;
    int          oe_cnt;

    always #5 clk_i = ~clk_i;

    line_ram_scheduler u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(frame_start), .frame_end_i(frame_end),
        .line_valid_i(line_valid), .data_valid_i(data_valid), .wr_addr_o(d_addr), .wr_sel_o(d_sel),
        .rd_center_o(d_rd), .line_odd_o(d_odd), .line_count_o(d_cnt), .out_enable_o(d_oe),
        .overflow_o(d_ov)
    );

    line_ram_scheduler #(.ADDR_WIDTH(3), .CNT_WIDTH(2), .MIN_LINES(3)) u_dut_small (
        .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(frame_start), .frame_end_i(frame_end),
        .line_valid_i(line_valid), .data_valid_i(data_valid), .wr_addr_o(a_addr), .wr_sel_o(a_sel),
        .rd_center_o(a_rd), .line_odd_o(a_odd), .line_count_o(a_cnt), .out_enable_o(a_oe),
        .overflow_o(a_ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Line valid rises one cycle ahead of the first word, as the CSI receiver delivers it.
    task automatic run_line(input int nwords);
        line_valid = 1'b1;
        data_valid = 1'b0;
        step();
        snap_sel = d_sel;
        snap_rd  = d_rd;
        snap_cnt = d_cnt;
        oe_cnt   = int'(d_oe);
        for (int k = 0; k < nwords; k++) begin
            data_valid = 1'b1;
            step();
            oe_cnt += int'(d_oe);
        end
        data_valid = 1'b0;
        line_valid = 1'b0;
        step();
        oe_cnt += int'(d_oe);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_sel [4];
        logic [1:0]  exp_rd  [4];
        int          exp_oe  [4];
        logic        gap_dv  [7];
        logic [9:0]  gap_addr[7];
        exp_sel  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_rd   = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_oe   = '{0, 0, 8, 8};
        gap_dv   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        gap_addr = '{10'd1, 10'd1, 10'd2, 10'd3, 10'd3, 10'd3, 10'd4};

        reset_i = 1'b1;
        repeat (2) step();
        chk("rst_sel", d_sel, 4'b1000);
        chk("rst_rd", d_rd, 2'd1);
        chk("rst_cnt", d_cnt, 12'd0);
        chk("rst_addr", d_addr, 10'd0);
        chk("rst_oe", d_oe, 1'b0);
        chk("rst_ov", d_ov, 1'b0);
        reset_i = 1'b0;
        step();

        // four lines of eight words
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            run_line(8);
            chk($sformatf("l%0d_sel", i + 1), snap_sel, exp_sel[i]);
            chk($sformatf("l%0d_rd", i + 1), snap_rd, exp_rd[i]);
            chk($sformatf("l%0d_cnt", i + 1), snap_cnt, 12'(i + 1));
            chk($sformatf("l%0d_oe_cycles", i + 1), oe_cnt, exp_oe[i]);
        end
        chk("l4_odd", d_odd, 1'b0);
        chk("l4_addr_idle", d_addr, 10'd0);
        chk("small_cnt_sat", a_cnt, 2'd3);
        chk("small_sel_rot", a_sel, 4'b1000);

        // address saturation on the 3-bit instance
        pulse_fs();
        chk("fs_clr_ov", a_ov, 1'b0);
        line_valid = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            data_valid = 1'b1;
            step();
            if (k == 7) begin
                chk("sat_w7_addr", a_addr, 3'd7);
                chk("sat_w7_ov", a_ov, 1'b0);
            end
            if (k == 8) chk("sat_w8_ov", a_ov, 1'b1);
            if (k == 10) begin
                chk("sat_w10_addr", a_addr, 3'd7);
                chk("big_w10_addr", d_addr, 10'd10);
            end
        end
        data_valid = 1'b0;
        line_valid = 1'b0;
        step();
        chk("sat_end_addr", a_addr, 3'd0);
        run_line(2);
        chk("sat_ov_sticky", a_ov, 1'b1);
        pulse_fs();
        chk("sat_ov_cleared", a_ov, 1'b0);

        // frame start coinciding with line start
        frame_start = 1'b1;
        line_valid  = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fsls_cnt", d_cnt, 12'd1);
        chk("fsls_sel", d_sel, 4'b0001);
        chk("fsls_rd", d_rd, 2'd2);
        chk("fsls_odd", d_odd, 1'b1);

        // data_valid gaps within a line
        for (int k = 0; k < 7; k++) begin
            data_valid = gap_dv[k];
            step();
            chk($sformatf("gap_addr%0d", k), d_addr, gap_addr[k]);
        end
        data_valid = 1'b0;
        line_valid = 1'b0;
        step();
        chk("gap_addr_end", d_addr, 10'd0);

        // frame end mid-line
        pulse_fs();
        for (int i = 0; i < 3; i++) run_line(2);
        line_valid = 1'b1;
        step();
        data_valid = 1'b1;
        repeat (2) step();
        chk("fe_oe_before", d_oe, 1'b1);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        chk("fe_oe_after", d_oe, 1'b0);
        data_valid = 1'b0;
        line_valid = 1'b0;
        step();
        run_line(4);
        chk("fe_cnt_held", snap_cnt, 12'd4);
        chk("fe_sel_held", snap_sel, 4'b1000);
        chk("fe_no_oe", oe_cnt, 0);

        // asynchronous reset mid-line
        pulse_fs();
        for (int i = 0; i < 3; i++) run_line(2);
        line_valid = 1'b1;
        step();
        data_valid = 1'b1;
        repeat (8) step();
        chk("pre_rst_oe", d_oe, 1'b1);
        chk("pre_rst_ov", a_ov, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_addr", d_addr, 10'd0);
        chk("arst_sel", d_sel, 4'b1000);
        chk("arst_rd", d_rd, 2'd1);
        chk("arst_cnt", d_cnt, 12'd0);
        chk("arst_oe", d_oe, 1'b0);
        chk("arst_ov", a_ov, 1'b0);
        reset_i = 1'b0;
        step();
        chk("post_rst_no_start", d_cnt, 12'd0);
        data_valid = 1'b0;
        line_valid = 1'b0;
        step();
        run_line(3);
        chk("idle_line_cnt", snap_cnt, 12'd0);
        chk("idle_line_sel", snap_sel, 4'b1000);
        chk("idle_line_rd", snap_rd, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_ram_scheduler.md
LINE_RAM_SCHEDULER -- requirements
Module: line_ram_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, line-RAM word address width (40-bit words, 4 pixels each).
REQ-002 SHALL have parameter CNT_WIDTH, default 12, line counter width.
REQ-003 SHALL have parameter MIN_LINES, default 3, lines buffered before output is enabled.
REQ-004 SHALL have port clk_i  in  1  byte clock; reset reset_i, asynchronous, active-high; clock clk_i.
REQ-005 SHALL have port reset_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have port frame_start_i  in  1  one-cycle pulse on CSI frame-start short packet.
REQ-007 SHALL have port frame_end_i  in  1  one-cycle pulse on CSI frame-end short packet.
REQ-008 SHALL have port line_valid_i  in  1  high for the duration of a line.
REQ-009 SHALL have port data_valid_i  in  1  4-pixel word valid.
REQ-010 SHALL have port wr_addr_o  out  ADDR_WIDTH  shared read/write address of the line RAMs.
REQ-011 SHALL have port wr_sel_o  out  4  one-hot line-RAM write select.
REQ-012 SHALL have port rd_center_o  out  2  index of the centre line RAM for the debayer window.
REQ-013 SHALL have port line_odd_o  out  1  parity of line_count_o (bit 0).
REQ-014 SHALL have port line_count_o  out  CNT_WIDTH  lines started in current frame.
REQ-015 SHALL have port out_enable_o  out  1  debayer output qualifier.
REQ-016 SHALL have port overflow_o  out  1  sticky line-too-long flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_LINE, IN_LINE, all transitions on posedge clk_i.
REQ-018 SHALL go IDLE->WAIT_LINE on frame_start_i; WAIT_LINE->IN_LINE on line start; IN_LINE->WAIT_LINE when line_valid_i is low; any state->IDLE on frame_end_i.
REQ-019 SHALL define line start as line_valid_i high with its registered copy low (synchronous edge detect); no signal SHALL be used as a clock.
REQ-020 SHALL, on frame_start_i: wr_sel_o=4'b1000, rd_center_o=2'd1, line_count_o=0, overflow_o=0.
REQ-021 SHALL, on line start in WAIT_LINE: rotate wr_sel_o left by one, increment rd_center_o mod 4, increment line_count_o; all visible one cycle after line start.
REQ-022 SHALL handle frame_start_i and line start in the same cycle as frame-start reset followed by one rotation: wr_sel_o=4'b0001, rd_center_o=2, line_count_o=1, state IN_LINE.
REQ-023 SHALL ignore line starts in IDLE; counters SHALL hold.
REQ-024 SHALL give frame_end_i priority over a simultaneous line start; the line start SHALL be ignored.
REQ-025 SHALL hold wr_addr_o at 0 while line_valid_i is low, and increment it by 1 on each data_valid_i while line_valid_i is high.
REQ-026 SHALL saturate wr_addr_o at 2^ADDR_WIDTH-1 and set overflow_o on a data_valid_i at saturation; overflow_o SHALL clear only on frame_start_i or reset.
REQ-027 SHALL saturate line_count_o at all-ones; rotation SHALL continue.
REQ-028 SHALL register out_enable_o = (state==IN_LINE) && data_valid_i && (line_count_o >= MIN_LINES), with 1-cycle latency.
REQ-029 SHALL drive line_odd_o = line_count_o[0], combinational from the register.
REQ-030 SHALL keep wr_sel_o exactly one-hot in all reachable states.

Reset
REQ-031 SHALL, on reset_i asserted at any time including mid-line, immediately set: state IDLE, wr_addr_o 0, wr_sel_o 4'b1000, rd_center_o 1, line_count_o 0, out_enable_o 0, overflow_o 0, edge-detect register 0.
REQ-032 SHALL not detect a line start on the first cycle after reset release if line_valid_i is already high while in IDLE.

Structure
REQ-033 SHALL place the FSM state encoding and the reset constants for wr_sel_o and rd_center_o in the shared debayer package.
REQ-034 SHALL be a single module with no sub-modules; the edge detector is inline.

Verification
REQ-035 SHALL cover: frame_start, then 4 lines of 8 words each -> wr_sel_o 0001,0010,0100,1000; rd_center_o 2,3,0,1; out_enable_o high only during lines 3-4 (8 cycles each, 1-cycle delayed).
REQ-036 SHALL cover: ADDR_WIDTH=3, a 10-word line -> wr_addr_o sticks at 7, overflow_o=1 from the 9th word until the next frame_start.
REQ-037 SHALL cover: frame_start and line_valid_i rising in the same cycle -> line_count_o=1, wr_sel_o=0001.
REQ-038 SHALL cover: frame_end_i mid-line -> IDLE, out_enable_o=0 next cycle, subsequent lines ignored with line_count_o held.
REQ-039 SHALL cover: reset_i pulsed mid-line (no clock edge) -> all outputs at reset values immediately; a line before frame_start is ignored.
REQ-040 SHALL cover: data_valid_i gaps within a line -> wr_addr_o advances only on valid words and returns to 0 when line_valid_i falls.
